// File: rtl/note_envelope_pkg.sv
// note_envelope_pkg: shared envelope state encoding and default widths.
package note_envelope_pkg;

   localparam int GAIN_W_DEF = 8;
   localparam int DUR_W      = 6;

   typedef enum logic [2:0] {
      IDLE,
      ATTACK,
      DECAY,
      SUSTAIN,
      RELEASE
   } env_state_t;

endpackage

// File: rtl/env_gain_fsm.sv
// env_gain_fsm: ADSR state machine producing the per-note envelope gain.
module env_gain_fsm
   import note_envelope_pkg::*;
#(
   parameter int GAIN_W        = GAIN_W_DEF,
   parameter int ATTACK_STEP   = 16,
   parameter int DECAY_STEP    = 1,
   parameter int SUSTAIN_LEVEL = 160,
   parameter int RELEASE_STEP  = 1,
   parameter int RELEASE_BEATS = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              note_start_i,
   input  logic [DUR_W-1:0]  note_duration_i,
   input  logic              note_done_i,
   input  logic              beat_i,
   input  logic              sample_in_rdy_i,
   output logic [GAIN_W-1:0] gain_o
);

   localparam logic [GAIN_W-1:0] GMAX   = '1;
   localparam logic [GAIN_W:0]   A_STEP = (GAIN_W+1)'(ATTACK_STEP);
   localparam logic [GAIN_W-1:0] D_STEP = GAIN_W'(DECAY_STEP);
   localparam logic [GAIN_W-1:0] SUS    = GAIN_W'(SUSTAIN_LEVEL);
   localparam logic [GAIN_W-1:0] R_STEP = GAIN_W'(RELEASE_STEP);
   localparam logic [DUR_W-1:0]  RB     = DUR_W'(RELEASE_BEATS);

   env_state_t        state_q, state_d;
   logic [GAIN_W-1:0] gain_q, gain_d, step_g, attack_g, decay_g, release_g;
   logic [GAIN_W:0]   attack_sum;
   logic [DUR_W-1:0]  beats_left_q, beats_left_d;
   logic              near_end;

   // Saturating/clamped gain step for the current state, taken only on accepted samples.
   always_comb begin
      attack_sum = {1'b0, gain_q} + A_STEP;
      attack_g   = (attack_sum > {1'b0, GMAX}) ? GMAX : attack_sum[GAIN_W-1:0];
      decay_g    = ({1'b0, gain_q} <= ({1'b0, SUS} + {1'b0, D_STEP})) ? SUS : gain_q - D_STEP;
      release_g  = (gain_q <= R_STEP) ? '0 : gain_q - R_STEP;
      step_g     = (state_q == ATTACK)  ? attack_g  :
                   (state_q == DECAY)   ? decay_g   :
                   (state_q == SUSTAIN) ? SUS       :
                   (state_q == RELEASE) ? release_g : '0;
      gain_d     = sample_in_rdy_i ? step_g : gain_q;
   end

   // Beat countdown and state transitions; a new note overrides beat and note_done.
   always_comb begin
      beats_left_d = note_start_i ? note_duration_i :
                     (beat_i && beats_left_q != '0) ? beats_left_q - 1'b1 : beats_left_q;
      near_end     = beats_left_q <= RB;
      state_d      = state_q;
      if (note_start_i)
         state_d = ATTACK;
      else if (note_done_i && state_q != IDLE)
         state_d = RELEASE;
      else
         case (state_q)
            ATTACK:  state_d = near_end ? RELEASE : (gain_d == GMAX) ? DECAY : ATTACK;
            DECAY:   state_d = near_end ? RELEASE : (gain_d == SUS) ? SUSTAIN : DECAY;
            SUSTAIN: state_d = near_end ? RELEASE : SUSTAIN;
            RELEASE: state_d = (gain_d == '0) ? IDLE : RELEASE;
            default: state_d = state_q;
         endcase
   end

   // State, gain and beat counter registers; reset drops any ramp in progress.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         gain_q       <= '0;
         beats_left_q <= '0;
      end else begin
         state_q      <= state_d;
         gain_q       <= gain_d;
         beats_left_q <= beats_left_d;
      end
   end

   assign gain_o = gain_q;

endmodule

// File: rtl/note_envelope.sv
// note_envelope: applies the ADSR gain to the summed note sample stream.
module note_envelope
   import note_envelope_pkg::*;
#(
   parameter int GAIN_W        = GAIN_W_DEF,
   parameter int ATTACK_STEP   = 16,
   parameter int DECAY_STEP    = 1,
   parameter int SUSTAIN_LEVEL = 160,
   parameter int RELEASE_STEP  = 1,
   parameter int RELEASE_BEATS = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              note_start_i,
   input  logic [DUR_W-1:0]  note_duration_i,
   input  logic              note_done_i,
   input  logic              beat_i,
   input  logic [15:0]       sample_in_i,
   input  logic              sample_in_rdy_i,
   output logic [15:0]       sample_out_o,
   output logic              sample_out_rdy_o,
   output logic [GAIN_W-1:0] gain_o
);

   logic [GAIN_W-1:0]        gain;
   logic signed [16+GAIN_W:0] prod;
   logic [15:0]              sample_out_q, sample_out_d;
   logic                     sample_out_rdy_q;
   logic                     unused_prod;

   env_gain_fsm #(
      .GAIN_W        (GAIN_W),
      .ATTACK_STEP   (ATTACK_STEP),
      .DECAY_STEP    (DECAY_STEP),
      .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
      .RELEASE_STEP  (RELEASE_STEP),
      .RELEASE_BEATS (RELEASE_BEATS)
   ) u_fsm (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .note_start_i    (note_start_i),
      .note_duration_i (note_duration_i),
      .note_done_i     (note_done_i),
      .beat_i          (beat_i),
      .sample_in_rdy_i (sample_in_rdy_i),
      .gain_o          (gain)
   );

   // Scale by the pre-step gain; the gain is zero-extended so it stays positive.
   always_comb begin
      prod         = $signed(sample_in_i) * $signed({1'b0, gain});
      sample_out_d = sample_in_rdy_i ? prod[15+GAIN_W:GAIN_W] : sample_out_q;
   end

   assign unused_prod = ^{prod[16+GAIN_W], prod[GAIN_W-1:0]};

   // Output register: new sample one cycle after each input strobe, held otherwise.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sample_out_q     <= '0;
         sample_out_rdy_q <= 1'b0;
      end else begin
         sample_out_q     <= sample_out_d;
         sample_out_rdy_q <= sample_in_rdy_i;
      end
   end

   assign sample_out_o     = sample_out_q;
   assign sample_out_rdy_o = sample_out_rdy_q;
   assign gain_o           = gain;

endmodule

// File: tb/tb_note_envelope.sv
// tb_note_envelope: scoreboard bench for the note envelope.
module tb_note_envelope;
   import note_envelope_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        note_start = 1'b0;
   logic [5:0]  note_duration = '0;
   logic        note_done = 1'b0;
   logic        beat = 1'b0;
   logic [15:0] sample_in = '0;
   logic        sample_in_rdy = 1'b0;
   logic [15:0] sample_out;
   logic        sample_out_rdy;
   logic [7:0]  gain;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   always #5 clk = ~clk;

   note_envelope dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .note_start_i     (note_start),
      .note_duration_i  (note_duration),
      .note_done_i      (note_done),
      .beat_i           (beat),
      .sample_in_i      (sample_in),
      .sample_in_rdy_i  (sample_in_rdy),
      .sample_out_o     (sample_out),
      .sample_out_rdy_o (sample_out_rdy),
      .gain_o           (gain)
   );

   function automatic logic [15:0] scaled(input logic [15:0] s, input logic [7:0] g);
      logic signed [31:0] p;
      p = 32'($signed(s)) * $signed({24'd0, g});
      return p[23:8];
   endfunction

   // Scoreboard: every ready strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (sample_out_rdy) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rdy_unexpected: sample_out=%h with nothing pending", sample_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sample_out !== mon_exp) begin
               fails++;
               $display("FAIL sample_out: got %h expected %h", sample_out, mon_exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [15:0] s, input logic [7:0] g, input int gap);
      tests++;
      if (gain !== g) begin
         fails++;
         $display("FAIL gain_before_strobe: got %0d expected %0d", gain, g);
      end
      sample_in     = s;
      sample_in_rdy = 1'b1;
      exp_q.push_back(scaled(s, g));
      @(negedge clk);
      sample_in_rdy = 1'b0;
      tick(gap);
   endtask

   task automatic start_note(input logic [5:0] dur);
      note_start    = 1'b1;
      note_duration = dur;
      @(negedge clk);
      note_start = 1'b0;
   endtask

   task automatic pulse_beat();
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
   endtask

   task automatic pulse_done();
      note_done = 1'b1;
      @(negedge clk);
      note_done = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(5);
      tests += 4;
      if (gain !== 8'd0) begin fails++; $display("FAIL reset_gain: got %0d expected 0", gain); end
      if (sample_out !== 16'h0) begin fails++; $display("FAIL reset_sample_out: got %h expected 0000", sample_out); end
      if (sample_out_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", sample_out_rdy); end
      if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.u_fsm.state_q); end
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_attack_ramp();
      start_note(6'd20);
      for (int i = 0; i < 16; i++) strobe(16'h4000, 8'(i * 16), 3);
      for (int g = 255; g > 160; g--) strobe(16'h4000, 8'(g), 3);
      tests++;
      if (dut.u_fsm.state_q !== SUSTAIN) begin fails++; $display("FAIL attack_sustain_state: got %0d expected SUSTAIN", dut.u_fsm.state_q); end
      for (int i = 0; i < 3; i++) strobe(16'h4000, 8'd160, 3);
   endtask

   task automatic test_release_beats();
      start_note(6'd6);
      strobe(16'h7fff, 8'd0, 1);
      strobe(16'h7fff, 8'd16, 1);
      pulse_beat();
      strobe(16'h7fff, 8'd32, 1);
      tests++;
      if (dut.u_fsm.state_q !== ATTACK) begin fails++; $display("FAIL beats_one_beat_state: got %0d expected ATTACK", dut.u_fsm.state_q); end
      strobe(16'h7fff, 8'd48, 1);
      pulse_beat();
      tick(1);
      tests++;
      if (dut.u_fsm.state_q !== RELEASE) begin fails++; $display("FAIL beats_release_state: got %0d expected RELEASE", dut.u_fsm.state_q); end
      for (int g = 64; g > 0; g--) strobe(16'h7fff, 8'(g), 1);
      tests++;
      if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL beats_idle_state: got %0d expected IDLE", dut.u_fsm.state_q); end
      strobe(16'h7fff, 8'd0, 1);
   endtask

   task automatic test_early_done();
      start_note(6'd40);
      for (int i = 0; i < 4; i++) strobe(16'hb000, 8'(i * 16), 1);
      pulse_done();
      tests++;
      if (dut.u_fsm.state_q !== RELEASE) begin fails++; $display("FAIL done_release_state: got %0d expected RELEASE", dut.u_fsm.state_q); end
      for (int g = 64; g > 0; g--) strobe(16'hb000, 8'(g), 1);
      tests++;
      if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL done_idle_state: got %0d expected IDLE", dut.u_fsm.state_q); end
   endtask

   task automatic test_retrigger();
      start_note(6'd30);
      for (int i = 0; i < 7; i++) strobe(16'h1234, 8'(i * 16), 1);
      pulse_done();
      for (int g = 112; g > 100; g--) strobe(16'h1234, 8'(g), 1);
      note_start    = 1'b1;
      note_duration = 6'd9;
      beat          = 1'b1;
      @(negedge clk);
      note_start = 1'b0;
      beat       = 1'b0;
      tests += 3;
      if (dut.u_fsm.state_q !== ATTACK) begin fails++; $display("FAIL retrig_state: got %0d expected ATTACK", dut.u_fsm.state_q); end
      if (gain !== 8'd100) begin fails++; $display("FAIL retrig_gain: got %0d expected 100", gain); end
      if (dut.u_fsm.beats_left_q !== 6'd9) begin fails++; $display("FAIL retrig_beats: got %0d expected 9", dut.u_fsm.beats_left_q); end
      strobe(16'h1234, 8'd100, 1);
      strobe(16'h1234, 8'd116, 1);
      apply_reset();
   endtask

   task automatic test_dur_zero();
      start_note(6'd0);
      tests++;
      if (dut.u_fsm.state_q !== ATTACK) begin fails++; $display("FAIL dur0_attack: got %0d expected ATTACK", dut.u_fsm.state_q); end
      tick(1);
      tests++;
      if (dut.u_fsm.state_q !== RELEASE) begin fails++; $display("FAIL dur0_release: got %0d expected RELEASE", dut.u_fsm.state_q); end
      tick(1);
      tests++;
      if (dut.u_fsm.state_q !== IDLE) begin fails++; $display("FAIL dur0_idle: got %0d expected IDLE", dut.u_fsm.state_q); end
      pulse_beat();
      tests++;
      if (dut.u_fsm.beats_left_q !== 6'd0) begin fails++; $display("FAIL beats_floor: got %0d expected 0", dut.u_fsm.beats_left_q); end
   endtask

   task automatic test_neg_full_scale();
      start_note(6'd50);
      for (int i = 0; i < 16; i++) strobe(16'h0000, 8'(i * 16), 1);
      strobe(16'h8000, 8'd255, 0);
      tests += 2;
      if (sample_out_rdy !== 1'b1) begin fails++; $display("FAIL negfs_rdy_high: got %b expected 1", sample_out_rdy); end
      if (sample_out !== 16'h8080) begin fails++; $display("FAIL negfs_value: got %h expected 8080", sample_out); end
      tick(1);
      tests += 2;
      if (sample_out_rdy !== 1'b0) begin fails++; $display("FAIL negfs_rdy_low: got %b expected 0", sample_out_rdy); end
      if (sample_out !== 16'h8080) begin fails++; $display("FAIL negfs_hold: got %h expected 8080", sample_out); end
      apply_reset();
   endtask

   initial begin
      tick(1);
      test_reset();
      test_attack_ramp();
      test_reset();
      test_release_beats();
      test_early_done();
      test_retrigger();
      test_dur_zero();
      test_neg_full_scale();
      tick(2);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_samples: got %0d outstanding expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
